// File: rtl/idct_pkg.sv
// Shared definitions for the IDCT transpose buffer.
//   blk_size_e     : block size codes carried on in_size / out_size
//   rd_state_e     : reader FSM states
//   log2n_of_size  : block edge log2 for a size code (2..5)
//   n_of_size      : block edge N for a size code (4/8/16/32)
//   beats_of_size  : N*N beats per block
//   size_supported : size code is legal and fits the configured banks
//   transpose_idx  : storage index of output beat k (column-major walk)
package idct_pkg;

  typedef enum logic [1:0] {
    Size4    = 2'b00,
    Size8    = 2'b01,
    Size16   = 2'b10,
    SizeRsvd = 2'b11
  } blk_size_e;

  typedef enum logic [0:0] {
    RdIdle  = 1'b0,
    RdDrain = 1'b1
  } rd_state_e;

  localparam int unsigned MinLog2N = 2;

  function automatic int unsigned log2n_of_size(logic [1:0] size);
    return MinLog2N + 32'(size);
  endfunction

  function automatic int unsigned n_of_size(logic [1:0] size);
    return 32'(1) << log2n_of_size(size);
  endfunction

  function automatic int unsigned beats_of_size(logic [1:0] size);
    return n_of_size(size) * n_of_size(size);
  endfunction

  function automatic logic size_supported(logic [1:0] size, int unsigned max_log2n);
    return (size != SizeRsvd) && (log2n_of_size(size) <= max_log2n);
  endfunction

  // Beat k of the drain reads row (k mod N), column (k div N); N is a power of two.
  function automatic int unsigned transpose_idx(int unsigned k, int unsigned log2n);
    int unsigned mask;
    mask = (32'(1) << log2n) - 1;
    return ((k & mask) << log2n) | (k >> log2n);
  endfunction

endpackage

// File: rtl/idct_bank_ram.sv
// One ping-pong bank: simple dual-port memory, one write port and one
// registered read port.
//   clk, rst_n       : clock, synchronous active-low reset (read register only)
//   wr_en/addr/data  : write port, written on the rising edge
//   rd_en/rd_addr    : read request; rd_data updates on the next rising edge
//   rd_data          : registered read data, holds while rd_en is low
module idct_bank_ram #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  localparam int unsigned Depth = 1 << ADDR_W;

  logic [DATA_W-1:0] mem_q [Depth];
  logic [DATA_W-1:0] rd_data_q;

  // Storage is never reset; only the read register has a defined reset value.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_data_q <= '0;
    end else if (rd_en) begin
      rd_data_q <= mem_q[rd_addr];
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/idct_transpose_buf.sv
// Ping-pong transpose buffer between the row and column IDCT passes.
// Blocks arrive row-major and leave column-major; one bank fills while the
// other drains.
//   clk, rst_n           : clock, synchronous active-low reset
//   in_valid/in_ready    : input handshake; in_ready low only while the write bank is full
//   in_size              : 00=4x4 01=8x8 10=16x16 11=reserved, sampled on beat 0
//   in_data              : coefficient, row-major
//   out_valid/out_ready  : output handshake
//   out_data             : sample, column-major
//   out_size             : size code of the block being drained
//   out_first/out_last   : first / final beat of a block
//   err                  : one-cycle pulse after a beat 0 with an unusable size was dropped
module idct_transpose_buf
  import idct_pkg::*;
#(
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned MAX_LOG2N = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_size,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        out_size,
  output logic              out_first,
  output logic              out_last,
  output logic              err
);

  localparam int unsigned AW = 2 * MAX_LOG2N;

  // Bank bookkeeping
  logic [1:0]      full_q, full_d;
  logic [1:0][1:0] bank_size_q;

  // Writer
  logic            wr_bank_q;
  logic [AW-1:0]   wr_cnt_q;
  logic [1:0]      wr_size_q;
  logic            err_q;
  logic            in_acc, wr_first, wr_bad, wr_last, wr_en, wr_done;
  logic [1:0]      wr_size_cur;

  // Reader
  rd_state_e       rd_state_q, rd_state_d;
  logic            rd_bank_q;
  logic [AW-1:0]   rd_cnt_q;
  logic [1:0]      rd_size_q;
  logic            rd_start, rd_fire, rd_last;
  logic [AW-1:0]   rd_addr;

  // Output stage
  logic              out_valid_q, out_first_q, out_last_q, out_bank_q;
  logic [1:0]        out_size_q;
  logic              out_free, out_release;
  logic [DATA_W-1:0] bank0_rdata, bank1_rdata;

  // ---------------------------------------------------------------------------
  // Writer
  // ---------------------------------------------------------------------------
  assign in_ready = ~full_q[wr_bank_q];

  always_comb begin
    in_acc      = in_valid && in_ready;
    wr_first    = (wr_cnt_q == '0);
    wr_bad      = wr_first && !size_supported(in_size, MAX_LOG2N);
    // Beat 0 uses the live size code; later beats use the latched one.
    wr_size_cur = wr_first ? in_size : wr_size_q;
    wr_last     = (wr_cnt_q == AW'(beats_of_size(wr_size_cur) - 1));
    wr_en       = in_acc && !wr_bad;
    wr_done     = wr_en && wr_last;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_bank_q <= 1'b0;
      wr_cnt_q  <= '0;
      wr_size_q <= Size4;
      err_q     <= 1'b0;
    end else begin
      // A rejected beat 0 leaves the count at zero, so the writer stays idle.
      err_q <= in_acc && wr_bad;
      if (wr_en) begin
        if (wr_first) begin
          wr_size_q <= in_size;
        end
        if (wr_last) begin
          wr_cnt_q  <= '0;
          wr_bank_q <= ~wr_bank_q;
        end else begin
          wr_cnt_q <= wr_cnt_q + AW'(1);
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Bank full flags: set by the writer on its last beat, cleared when the
  // reader's out_last is accepted. They can never target the same bank in one
  // cycle because the writer only ever owns a bank that is not full.
  // ---------------------------------------------------------------------------
  always_comb begin
    full_d = full_q;
    if (out_release) begin
      full_d[out_bank_q] = 1'b0;
    end
    if (wr_done) begin
      full_d[wr_bank_q] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      full_q      <= '0;
      bank_size_q <= '0;
    end else begin
      full_q <= full_d;
      if (wr_done) begin
        bank_size_q[wr_bank_q] <= wr_size_cur;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Reader FSM. DRAIN covers issuing reads; the bank stays full until its last
  // beat is accepted downstream, which lets the next bank start issuing while
  // the previous out_last is still waiting in the output register.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_state_q <= RdIdle;
    end else begin
      rd_state_q <= rd_state_d;
    end
  end

  always_comb begin
    rd_state_d = rd_state_q;
    unique case (rd_state_q)
      RdIdle: begin
        if (full_q[rd_bank_q]) begin
          rd_state_d = RdDrain;
        end
      end
      RdDrain: begin
        // Roll straight into the other bank when it is already full.
        if (rd_fire && rd_last && !full_q[~rd_bank_q]) begin
          rd_state_d = RdIdle;
        end
      end
      default: rd_state_d = RdIdle;
    endcase
  end

  always_comb begin
    rd_start = 1'b0;
    rd_fire  = 1'b0;
    unique case (rd_state_q)
      RdIdle:  rd_start = full_q[rd_bank_q];
      RdDrain: rd_fire  = out_free;
      default: ;
    endcase
  end

  assign rd_last = (rd_cnt_q == AW'(beats_of_size(rd_size_q) - 1));
  assign rd_addr = AW'(transpose_idx(32'(rd_cnt_q), log2n_of_size(rd_size_q)));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_bank_q <= 1'b0;
      rd_cnt_q  <= '0;
      rd_size_q <= Size4;
    end else if (rd_start) begin
      rd_cnt_q  <= '0;
      rd_size_q <= bank_size_q[rd_bank_q];
    end else if (rd_fire) begin
      if (rd_last) begin
        rd_cnt_q  <= '0;
        rd_bank_q <= ~rd_bank_q;
        // Only meaningful when continuing; an IDLE restart reloads it.
        rd_size_q <= bank_size_q[~rd_bank_q];
      end else begin
        rd_cnt_q <= rd_cnt_q + AW'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Output stage. The RAM read register is the data register; it only advances
  // when a read is issued, so a stall freezes data and sideband together.
  // ---------------------------------------------------------------------------
  assign out_free    = !out_valid_q || out_ready;
  assign out_release = out_valid_q && out_ready && out_last_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_first_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_size_q  <= Size4;
      out_bank_q  <= 1'b0;
    end else if (rd_fire) begin
      out_valid_q <= 1'b1;
      out_first_q <= (rd_cnt_q == '0);
      out_last_q  <= rd_last;
      out_size_q  <= rd_size_q;
      out_bank_q  <= rd_bank_q;
    end else if (out_ready) begin
      out_valid_q <= 1'b0;
      out_first_q <= 1'b0;
      out_last_q  <= 1'b0;
    end
  end

  assign out_valid = out_valid_q;
  assign out_first = out_first_q;
  assign out_last  = out_last_q;
  assign out_size  = out_size_q;
  assign out_data  = out_bank_q ? bank1_rdata : bank0_rdata;
  assign err       = err_q;

  // ---------------------------------------------------------------------------
  // Banks
  // ---------------------------------------------------------------------------
  idct_bank_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (AW)
  ) u_bank0 (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_en && !wr_bank_q),
    .wr_addr (wr_cnt_q),
    .wr_data (in_data),
    .rd_en   (rd_fire && !rd_bank_q),
    .rd_addr (rd_addr),
    .rd_data (bank0_rdata)
  );

  idct_bank_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (AW)
  ) u_bank1 (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_en && wr_bank_q),
    .wr_addr (wr_cnt_q),
    .wr_data (in_data),
    .rd_en   (rd_fire && rd_bank_q),
    .rd_addr (rd_addr),
    .rd_data (bank1_rdata)
  );

endmodule

// File: tb/tb_idct_transpose_buf.sv
// Bench for idct_transpose_buf: a block-level model (completed blocks are
// transposed into an expected-beat queue) checked every cycle, plus directed
// literal checks on timing, ordering and reset behaviour.
module tb_idct_transpose_buf;

  localparam int unsigned DW        = 16;
  localparam int unsigned MAX_LOG2N = 4;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [1:0]    size;
    logic          first;
    logic          last;
  } beat_t;

  logic          clk, rst_n;
  logic          in_valid, in_ready, out_valid, out_ready, out_first, out_last, err;
  logic [1:0]    in_size, out_size;
  logic [DW-1:0] in_data, out_data;

  idct_transpose_buf #(
    .DATA_W    (DW),
    .MAX_LOG2N (MAX_LOG2N)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_size   (in_size),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_size  (out_size),
    .out_first (out_first),
    .out_last  (out_last),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int ready_mode = 0;  // 0: ready high, 1: ready low, 2: random
  int t_acc = 0;

  beat_t exp_q[$];
  beat_t log_q[$];
  int    log_cyc[$];

  // Block-level model state
  logic [DW-1:0] m_buf [256];
  int            m_cnt = 0;
  int            m_n = 4;
  logic [1:0]    m_size = 2'b00;
  int            outstanding = 0;
  bit            err_exp = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_cnt       = 0;
    outstanding = 0;
    err_exp     = 1'b0;
  endtask

  task automatic model_in(input logic [1:0] sz, input logic [DW-1:0] d);
    beat_t b;
    int    nn;
    if (m_cnt == 0) begin
      if (sz == 2'b11 || (4 << sz) > (1 << MAX_LOG2N)) begin
        err_exp = 1'b1;
        return;
      end
      m_n    = 4 << sz;
      m_size = sz;
    end
    m_buf[m_cnt] = d;
    m_cnt++;
    nn = m_n * m_n;
    if (m_cnt == nn) begin
      for (int k = 0; k < nn; k++) begin
        b.data  = m_buf[(k % m_n) * m_n + (k / m_n)];
        b.size  = m_size;
        b.first = (k == 0);
        b.last  = (k == nn - 1);
        exp_q.push_back(b);
      end
      m_cnt = 0;
      outstanding++;
    end
  endtask

  // Compare process: check current outputs, then fold in the handshakes that
  // will complete on the coming rising edge.
  always @(negedge clk) begin
    beat_t b;
    if (!rst_n) begin
      model_reset();
    end else begin
      chk("in_ready", {63'b0, in_ready}, {63'b0, outstanding < 2});
      chk("err", {63'b0, err}, {63'b0, err_exp});
      err_exp = 1'b0;
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          chk("out_valid_idle", {63'b0, out_valid}, 64'd0);
        end else begin
          chk("out_data", {48'b0, out_data}, {48'b0, exp_q[0].data});
          chk("out_size", {62'b0, out_size}, {62'b0, exp_q[0].size});
          chk("out_first", {63'b0, out_first}, {63'b0, exp_q[0].first});
          chk("out_last", {63'b0, out_last}, {63'b0, exp_q[0].last});
          if (out_ready) begin
            b.data  = out_data;
            b.size  = out_size;
            b.first = out_first;
            b.last  = out_last;
            log_q.push_back(b);
            log_cyc.push_back(cyc);
            if (exp_q[0].last) outstanding--;
            void'(exp_q.pop_front());
          end
        end
      end
      if (in_valid && in_ready) model_in(in_size, in_data);
    end
  end

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'b0;
        default: out_ready = 1'($urandom_range(1));
      endcase
    end
  end

  initial begin
    repeat (80000) @(posedge clk);
    $display("FAIL watchdog: cycle budget exhausted at %0d", cyc);
    $fatal(1, "watchdog");
  end

  // Drivers change inputs only at rising edge + 1.
  task automatic send_beat(input logic [1:0] sz, input logic [DW-1:0] d);
    int budget;
    bit done;
    budget   = 4000;
    done     = 1'b0;
    in_valid = 1'b1;
    in_size  = sz;
    in_data  = d;
    while (!done && budget > 0) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        #1;
        done  = 1'b1;
        t_acc = cyc;
      end else begin
        budget--;
      end
    end
    in_valid = 1'b0;
    if (!done) begin
      chk("send_timeout", {63'b0, in_ready}, 64'd1);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_block(input logic [1:0] sz, input bit rnd, input int gap_pct);
    int n;
    n = 4 << sz;
    for (int k = 0; k < n * n; k++) begin
      if (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
        @(posedge clk);
        #1;
      end
      send_beat(sz, rnd ? DW'($urandom()) : DW'(k));
    end
  endtask

  task automatic wait_drain();
    int budget;
    budget = 6000;
    while (exp_q.size() != 0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    chk("drain_timeout", 64'(exp_q.size()), 64'd0);
    repeat (3) @(negedge clk);
    chk("idle_after_drain", {63'b0, out_valid}, 64'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_out_valid"}, {63'b0, out_valid}, 64'd0);
    chk({tag, "_out_first"}, {63'b0, out_first}, 64'd0);
    chk({tag, "_out_last"}, {63'b0, out_last}, 64'd0);
    chk({tag, "_err"}, {63'b0, err}, 64'd0);
    chk({tag, "_out_size"}, {62'b0, out_size}, 64'd0);
    chk({tag, "_out_data"}, {48'b0, out_data}, 64'd0);
    chk({tag, "_in_ready"}, {63'b0, in_ready}, 64'd1);
  endtask

  int lit4 [16] = '{0, 4, 8, 12, 1, 5, 9, 13, 2, 6, 10, 14, 3, 7, 11, 15};

  initial begin
    int t_v;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_size  = 2'b00;
    in_data  = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("por");
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 4x4 ramp: order, first/last flags, two-cycle latency
    log_q.delete();
    log_cyc.delete();
    send_block(2'b00, 1'b0, 0);
    t_v = 0;
    for (int i = 0; i < 10 && t_v == 0; i++) begin
      @(negedge clk);
      if (out_valid) t_v = cyc;
    end
    chk("first_valid_latency", 64'(t_v - t_acc), 64'd2);
    wait_drain();
    chk("t4_count", 64'(log_q.size()), 64'd16);
    if (log_q.size() == 16) begin
      for (int i = 0; i < 16; i++) chk("t4_order", {48'b0, log_q[i].data}, 64'(lit4[i]));
      chk("t4_first", {63'b0, log_q[0].first}, 64'd1);
      chk("t4_last", {63'b0, log_q[15].last}, 64'd1);
      chk("t4_mid_flags", {62'b0, log_q[7].first, log_q[7].last}, 64'd0);
    end

    // 8x8 then 4x4 back to back with no bubble between blocks
    log_q.delete();
    log_cyc.delete();
    send_block(2'b01, 1'b1, 0);
    send_block(2'b00, 1'b1, 0);
    wait_drain();
    chk("b2b_count", 64'(log_q.size()), 64'd80);
    if (log_q.size() == 80) begin
      chk("b2b_no_gap", 64'(log_cyc[79] - log_cyc[0]), 64'd79);
      chk("b2b_size_a", {62'b0, log_q[63].size}, 64'd1);
      chk("b2b_last_a", {63'b0, log_q[63].last}, 64'd1);
      chk("b2b_size_b", {62'b0, log_q[64].size}, 64'd0);
      chk("b2b_first_b", {63'b0, log_q[64].first}, 64'd1);
    end

    // Two 16x16 blocks under a long stall; a third is held off
    log_q.delete();
    log_cyc.delete();
    ready_mode = 1;
    @(posedge clk);
    #1;
    send_block(2'b10, 1'b0, 0);
    send_block(2'b10, 1'b0, 0);
    repeat (500) begin
      @(posedge clk);
      #1;
    end
    in_valid = 1'b1;
    in_size  = 2'b10;
    in_data  = '0;
    @(negedge clk);
    chk("third_block_blocked", {63'b0, in_ready}, 64'd0);
    @(posedge clk);
    #1;
    in_valid   = 1'b0;
    ready_mode = 0;
    send_block(2'b10, 1'b0, 0);
    wait_drain();
    chk("t16_count", 64'(log_q.size()), 64'd768);
    if (log_q.size() == 768) begin
      chk("t16_beat1", {48'b0, log_q[1].data}, 64'd16);
      chk("t16_beat16", {48'b0, log_q[16].data}, 64'd1);
      chk("t16_beat255", {48'b0, log_q[255].data}, 64'd255);
      chk("t16_second_first", {63'b0, log_q[256].first}, 64'd1);
      chk("t16_third_beat1", {48'b0, log_q[513].data}, 64'd16);
    end

    // Reserved size on beat 0 is dropped with a one-cycle err pulse
    send_beat(2'b11, DW'(16'hdead));
    @(negedge clk);
    chk("err_pulse", {63'b0, err}, 64'd1);
    @(negedge clk);
    chk("err_one_cycle", {63'b0, err}, 64'd0);
    chk("err_no_output", {63'b0, out_valid}, 64'd0);
    @(posedge clk);
    #1;
    log_q.delete();
    log_cyc.delete();
    send_block(2'b00, 1'b0, 0);
    wait_drain();
    chk("after_err_count", 64'(log_q.size()), 64'd16);
    if (log_q.size() == 16) chk("after_err_beat1", {48'b0, log_q[1].data}, 64'd4);

    // Random ready and input gaps over mixed sizes
    ready_mode = 2;
    send_block(2'b01, 1'b1, 30);
    for (int i = 0; i < 3; i++) send_block(2'($urandom_range(2)), 1'b1, 20);
    wait_drain();
    ready_mode = 0;

    // Reset at beat 30 of an 8x8 while a stalled block is pending
    ready_mode = 1;
    @(posedge clk);
    #1;
    send_block(2'b01, 1'b1, 0);
    for (int k = 0; k < 30; k++) send_beat(2'b01, DW'($urandom()));
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk_reset_outputs("mid_rst");
    rst_n      = 1'b1;
    ready_mode = 0;
    @(posedge clk);
    #1;
    log_q.delete();
    log_cyc.delete();
    send_block(2'b00, 1'b0, 0);
    wait_drain();
    chk("post_rst_count", 64'(log_q.size()), 64'd16);
    if (log_q.size() == 16) begin
      chk("post_rst_beat1", {48'b0, log_q[1].data}, 64'd4);
      chk("post_rst_size", {62'b0, log_q[0].size}, 64'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/idct_transpose_buf.md
IDCT_TRANSPOSE_BUF -- requirements
Module: idct_transpose_buf

Interface
REQ-001 SHALL have parameter DATA_W, default 16, coefficient/sample width (signed).
REQ-002 SHALL have parameter MAX_LOG2N, default 4, log2 of largest supported block edge (4 gives 16x16).
REQ-003 SHALL have port clk  input  1  clock, all logic on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port in_valid  input  1  input beat offered.
REQ-006 SHALL have port in_ready  output  1  input beat accepted when in_valid&&in_ready.
REQ-007 SHALL have port in_size  input  2  block size: 00=4x4, 01=8x8, 10=16x16, 11=reserved; sampled on first beat of a block only.
REQ-008 SHALL have port in_data  input  DATA_W  coefficient, row-major order.
REQ-009 SHALL have port out_valid  output  1  output beat offered.
REQ-010 SHALL have port out_ready  input  1  downstream accepts when out_valid&&out_ready.
REQ-011 SHALL have port out_data  output  DATA_W  sample, column-major (transposed) order.
REQ-012 SHALL have port out_size  output  2  size code of block being drained.
REQ-013 SHALL have port out_first  output  1  high on first beat of a block.
REQ-014 SHALL have port out_last  output  1  high on final beat of a block.
REQ-015 SHALL have port err  output  1  one-cycle pulse on rejected reserved/oversize in_size.

Function
REQ-016 SHALL contain two banks (ping-pong), each 2^(2*MAX_LOG2N) x DATA_W; writer and reader alternate banks.
REQ-017 Writer SHALL fill bank at index r*N+c, beat count 0..N*N-1, N=4<<in_size; size latched on beat 0.
REQ-018 Size code 11, or N > 2^MAX_LOG2N, on beat 0 SHALL drop that beat, pulse err next cycle, leave writer idle.
REQ-019 in_ready SHALL be high iff the current write bank is not full; reset value 1.
REQ-020 On acceptance of beat N*N-1 the write bank SHALL be marked full with its size, and writer SHALL switch to the other bank.
REQ-021 Reader states SHALL be IDLE, DRAIN; IDLE->DRAIN when the read bank is full; DRAIN->IDLE (or stays DRAIN on next full bank) after out_last accepted.
REQ-022 Output beat k SHALL equal stored element at index (k mod N)*N + (k div N), k=0..N*N-1.
REQ-023 out_valid SHALL first rise exactly 2 cycles after the clock edge accepting the last input beat (one cycle flag, one cycle registered read).
REQ-024 While out_valid && !out_ready, out_data/out_size/out_first/out_last SHALL be held stable.
REQ-025 With out_ready held high, a block SHALL drain at one beat per cycle, no bubbles within a block, and back-to-back full banks SHALL drain with no bubble between blocks.
REQ-026 Bank release (reader accepting out_last) and writer needing that bank in the same cycle SHALL make in_ready high the following cycle.
REQ-027 Both banks full SHALL hold in_ready low until a bank is released; no input beat lost or overwritten.
REQ-028 Mixed sizes in consecutive blocks SHALL each drain with their own latched out_size.

Reset
REQ-029 rst_n low SHALL clear: out_valid=0, out_first=0, out_last=0, err=0, out_size=00, out_data=0, in_ready=1, both bank-full flags, counters, bank pointers, reader to IDLE.
REQ-030 Reset mid-block SHALL discard partial input and any undrained output; memory contents need not be cleared.

Structure
REQ-031 Size codes, N lookup (4/8/16/32), reader state encoding SHALL live in shared package idct_pkg.
REQ-032 Banks SHALL be one sub-module idct_bank_ram (1 write, 1 registered read port), instantiated twice.

Verification
REQ-033 4x4 block in_data=0..15, out_ready=1 -> out 0,4,8,12,1,5,...,15; first out_valid 2 cycles after beat 15; out_first on 0, out_last on 15.
REQ-034 8x8 then 4x4 back-to-back, out_ready=1 -> 64 transposed beats out_size=01 then 16 beats out_size=00, no gap.
REQ-035 16x16 value=index, out_ready low 500 cycles -> second block accepted, third block sees in_ready=0 after 0 beats; releasing out_ready drains 256+256 beats, correct order.
REQ-036 in_size=11 on beat 0 -> err pulse one cycle, no output; following valid 4x4 block processes normally.
REQ-037 Random out_ready toggling on 8x8 -> output held stable on stall, sequence matches REQ-022.
REQ-038 rst_n low at beat 30 of 8x8 -> all outputs at reset values next cycle; subsequent 4x4 block correct.
